instr_fetch: RTL and testbench

Instruction-fetch stage directly upstream of the memory-access stage. Walks a 16-bit fetch PC, issues single-byte read requests on the memory-access handshake, and buffers returned opcode/operand bytes with their addresses in a small prefetch queue. The decoder drains the queue through a valid/ready handshake. A redirect input (jump/branch/interrupt) flushes the queue and restarts fetching at a new target.

---
 rtl/mosby_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 90 +++++++++
 rtl/instr_fetch.sv | 172 +++++++++++++++++
 tb/tb_instr_fetch.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mosby_pkg.sv
// Shared definitions for the fetch front end: fetch FSM states, address
// width, default reset PC and a small PC increment helper.
package mosby_pkg;

    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'hFFFC;

    // IDLE: nothing outstanding; REQ: live request awaiting ack;
    // DROP: a request issued before a redirect is still outstanding and
    // its returned byte must be thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // Next sequential byte address; wraps 16'hFFFF -> 16'h0000.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {8-bit data, 16-bit pc}.
// Flush has priority over push and pop. Push while full is accepted only
// when a pop frees an entry in the same cycle; pop while empty is ignored.
module fetch_queue
    import mosby_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [7:0]        push_data,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              pop,
    output logic [7:0]        head_data,
    output logic [ADDR_W-1:0] head_pc,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [7:0]        data_q [DEPTH];
    logic [7:0]        data_d [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = data_q[rd_ptr_q];
    assign head_pc   = pc_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        data_d   = data_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                data_d[wr_ptr_q] = push_data;
                pc_d[wr_ptr_q]   = push_pc;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + {{(CNT_W-1){1'b0}}, do_push}
                              - {{(CNT_W-1){1'b0}}, do_pop};
        end
    end

    // Queue registers with asynchronous active-low reset.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage. Walks a fetch PC, issues single-byte reads to
// the memory-access stage, buffers returned bytes with their addresses in
// a prefetch queue and hands them to the decoder. A redirect flushes the
// queue and restarts fetching at the new target.
//
// Handshakes: the memory side is request/acknowledge -- mem_req and
// mem_addr are registered and held until a one-cycle mem_ack returns the
// byte on mem_rdata; at most one request is ever outstanding. The decoder
// side is valid/ready -- the head entry transfers on any rising edge where
// ib_valid & ib_ready, and ib_ready while ib_valid=0 has no effect.
//
// Optional build macro FETCH_BYPASS_EN: with the queue empty, an ack that
// meets ib_ready (and no redirect) is forwarded to ib_* in the same cycle
// instead of being queued.
module instr_fetch
    import mosby_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk_1,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              ib_valid,
    output logic [7:0]        ib_data,
    output logic [ADDR_W-1:0] ib_pc,
    input  logic              ib_ready,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

    logic              q_push;
    logic              q_pop;
    logic [7:0]        q_head_data;
    logic [ADDR_W-1:0] q_head_pc;
    logic [CNT_W-1:0]  q_count;
    logic              q_full;
    logic              q_empty;
    logic              bypass;
    logic [CNT_W:0]    cnt_after;
    logic              room_after;

`ifdef FETCH_BYPASS_EN
    assign bypass = (state_q == REQ) & mem_ack & ib_ready & ~jmp_valid & q_empty;
`else
    assign bypass = 1'b0;
`endif

    // A redirect voids any same-cycle push or pop.
    assign q_push = (state_q == REQ) & mem_ack & ~jmp_valid & ~bypass;
    assign q_pop  = ib_ready & ~q_empty & ~jmp_valid;

    // Occupancy after this edge; a follow-on request needs one more slot.
    assign cnt_after  = {1'b0, q_count} + {{CNT_W{1'b0}}, q_push}
                                        - {{CNT_W{1'b0}}, q_pop};
    assign room_after = (cnt_after < DEPTH_W);

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk_1     (clk_1),
        .rst       (rst),
        .flush     (jmp_valid),
        .push      (q_push),
        .push_data (mem_rdata),
        .push_pc   (mem_addr_q),
        .pop       (q_pop),
        .head_data (q_head_data),
        .head_pc   (q_head_pc),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Fetch FSM next-state and request/PC updates.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: begin
                if (jmp_valid) begin
                    fetch_pc_d = jmp_target;
                end else if (!q_full) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (jmp_valid) begin
                        // Byte is discarded; restart straight at the target.
                        mem_addr_d = jmp_target;
                        fetch_pc_d = jmp_target;
                    end else begin
                        fetch_pc_d = pc_inc(mem_addr_q);
                        if (room_after) begin
                            mem_addr_d = pc_inc(mem_addr_q);
                        end else begin
                            state_d   = IDLE;
                            mem_req_d = 1'b0;
                        end
                    end
                end else if (jmp_valid) begin
                    // Request stays on the bus until its ack arrives.
                    state_d    = DROP;
                    fetch_pc_d = jmp_target;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_d    = REQ;
                    mem_addr_d = jmp_valid ? jmp_target : fetch_pc_q;
                    fetch_pc_d = jmp_valid ? jmp_target : fetch_pc_q;
                end else if (jmp_valid) begin
                    fetch_pc_d = jmp_target;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Fetch FSM and request registers with asynchronous active-low reset.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign dbg_state = state_q;

    // Decoder-facing outputs; empty queue presents zeros.
    always_comb begin
        ib_valid = ~q_empty;
        ib_data  = q_empty ? 8'h00 : q_head_data;
        ib_pc    = q_empty ? '0 : q_head_pc;
        if (bypass) begin
            ib_valid = 1'b1;
            ib_data  = mem_rdata;
            ib_pc    = mem_addr_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (DEPTH=4, RESET_PC=16'hFFFC).
// Inputs are driven 1 time unit after a rising edge, outputs are checked
// 1 time unit later. Expected bytes come from byte_at(addr).
module tb_instr_fetch;
    import mosby_pkg::*;

    logic        clk_1 = 1'b0;
    logic        rst   = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack    = 1'b0;
    logic [7:0]  mem_rdata  = 8'h00;
    logic        ib_valid;
    logic [7:0]  ib_data;
    logic [15:0] ib_pc;
    logic        ib_ready   = 1'b0;
    logic        jmp_valid  = 1'b0;
    logic [15:0] jmp_target = 16'h0000;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_1 = ~clk_1;

    instr_fetch #(
        .DEPTH    (4),
        .RESET_PC (16'hFFFC)
    ) dut (
        .clk_1      (clk_1),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ib_valid   (ib_valid),
        .ib_data    (ib_data),
        .ib_pc      (ib_pc),
        .ib_ready   (ib_ready),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .dbg_state  (dbg_state)
    );

    function automatic logic [7:0] byte_at(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic step();
        @(posedge clk_1);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        mem_ack    = 1'b0;
        mem_rdata  = 8'h00;
        ib_ready   = 1'b0;
        jmp_valid  = 1'b0;
        jmp_target = 16'h0000;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        settle();
        n_checks++;
        if ({mem_req, mem_addr, ib_valid, ib_data, ib_pc, dbg_state} !== {1'b0, 16'hFFFC, 1'b0, 8'h00, 16'h0000, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got req=%b addr=%h v=%b d=%h pc=%h st=%0d want req=0 addr=fffc v=0 d=00 pc=0000 st=0",
                     mem_req, mem_addr, ib_valid, ib_data, ib_pc, dbg_state);
        end
        rst = 1'b1;
        step();
        settle();
        n_checks++;
        if ({mem_req, mem_addr, dbg_state} !== {1'b1, 16'hFFFC, 2'd1}) begin
            n_fail++;
            $display("FAIL first_request: got req=%b addr=%h st=%0d want req=1 addr=fffc st=1", mem_req, mem_addr, dbg_state);
        end
    endtask

    task automatic test_sequential();
        logic [15:0] exp;
        logic [15:0] prev;
        apply_reset();
        ib_ready = 1'b1;
        step();
        prev = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            exp = 16'hFFFC + 16'(i);
            mem_ack = 1'b0;
            settle();
            n_checks++;
            if ({mem_req, mem_addr} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL seq_req[%0d]: got req=%b addr=%h want req=1 addr=%h", i, mem_req, mem_addr, exp);
            end
`ifdef FETCH_BYPASS_EN
            n_checks++;
            if (ib_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_nobyte[%0d]: got v=%b want v=0", i, ib_valid);
            end
`else
            if (i > 0) begin
                n_checks++;
                if ({ib_valid, ib_pc, ib_data} !== {1'b1, prev, byte_at(prev)}) begin
                    n_fail++;
                    $display("FAIL seq_byte[%0d]: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                             i, ib_valid, ib_pc, ib_data, prev, byte_at(prev));
                end
            end
`endif
            step();
            mem_ack   = 1'b1;
            mem_rdata = byte_at(exp);
            settle();
            n_checks++;
`ifdef FETCH_BYPASS_EN
            if ({mem_addr, ib_valid, ib_pc, ib_data} !== {exp, 1'b1, exp, byte_at(exp)}) begin
`else
            if ({mem_addr, ib_valid} !== {exp, 1'b0}) begin
`endif
                n_fail++;
                $display("FAIL seq_ack[%0d]: got addr=%h v=%b pc=%h d=%h want addr=%h", i, mem_addr, ib_valid, ib_pc, ib_data, exp);
            end
            step();
            prev = exp;
        end
        mem_ack = 1'b0;
        settle();
`ifndef FETCH_BYPASS_EN
        n_checks++;
        if ({ib_valid, ib_pc, ib_data} !== {1'b1, 16'h0000, byte_at(16'h0000)}) begin
            n_fail++;
            $display("FAIL seq_last: got v=%b pc=%h d=%h want v=1 pc=0000 d=%h", ib_valid, ib_pc, ib_data, byte_at(16'h0000));
        end
`endif
    endtask

    task automatic test_fill();
        logic [15:0] exp;
        apply_reset();
        ib_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            exp       = 16'hFFFC + 16'(i);
            mem_ack   = 1'b1;
            mem_rdata = byte_at(exp);
            settle();
            n_checks++;
            if ({mem_req, mem_addr} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL fill_req[%0d]: got req=%b addr=%h want req=1 addr=%h", i, mem_req, mem_addr, exp);
            end
            step();
        end
        // Acks with no request outstanding must be ignored.
        for (int i = 0; i < 2; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'hEE;
            settle();
            n_checks++;
            if ({mem_req, dbg_state, ib_valid, ib_pc, ib_data} !== {1'b0, 2'd0, 1'b1, 16'hFFFC, byte_at(16'hFFFC)}) begin
                n_fail++;
                $display("FAIL fill_stall[%0d]: got req=%b st=%0d v=%b pc=%h d=%h want req=0 st=0 v=1 pc=fffc",
                         i, mem_req, dbg_state, ib_valid, ib_pc, ib_data);
            end
            step();
        end
        mem_ack  = 1'b0;
        ib_ready = 1'b1;
        settle();
        n_checks++;
        if ({mem_req, ib_pc} !== {1'b0, 16'hFFFC}) begin
            n_fail++;
            $display("FAIL fill_drain0: got req=%b pc=%h want req=0 pc=fffc", mem_req, ib_pc);
        end
        step();
        settle();
        n_checks++;
        if ({mem_req, ib_valid, ib_pc, ib_data} !== {1'b0, 1'b1, 16'hFFFD, byte_at(16'hFFFD)}) begin
            n_fail++;
            $display("FAIL fill_drain1: got req=%b v=%b pc=%h d=%h want req=0 v=1 pc=fffd", mem_req, ib_valid, ib_pc, ib_data);
        end
        step();
        settle();
        n_checks++;
        if ({mem_req, mem_addr, ib_pc, ib_data} !== {1'b1, 16'h0000, 16'hFFFE, byte_at(16'hFFFE)}) begin
            n_fail++;
            $display("FAIL fill_resume: got req=%b addr=%h pc=%h d=%h want req=1 addr=0000 pc=fffe", mem_req, mem_addr, ib_pc, ib_data);
        end
        step();
        settle();
        n_checks++;
        if ({ib_valid, ib_pc, ib_data} !== {1'b1, 16'hFFFF, byte_at(16'hFFFF)}) begin
            n_fail++;
            $display("FAIL fill_drain3: got v=%b pc=%h d=%h want v=1 pc=ffff", ib_valid, ib_pc, ib_data);
        end
        step();
        settle();
        n_checks++;
        if ({ib_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL fill_empty: got v=%b req=%b addr=%h want v=0 req=1 addr=0000", ib_valid, mem_req, mem_addr);
        end
    endtask

    task automatic test_redirect_drop();
        apply_reset();
        ib_ready = 1'b1;
        step();
        jmp_valid  = 1'b1;
        jmp_target = 16'h1234;
        settle();
        step();
        jmp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++;
            if ({mem_req, mem_addr, ib_valid, dbg_state} !== {1'b1, 16'hFFFC, 1'b0, 2'd2}) begin
                n_fail++;
                $display("FAIL drop_hold[%0d]: got req=%b addr=%h v=%b st=%0d want req=1 addr=fffc v=0 st=2",
                         i, mem_req, mem_addr, ib_valid, dbg_state);
            end
            step();
        end
        mem_ack   = 1'b1;
        mem_rdata = 8'hC3;
        settle();
        n_checks++;
        if (ib_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_stale_ack: got v=%b want v=0", ib_valid);
        end
        step();
        mem_ack = 1'b0;
        settle();
        n_checks++;
        if ({mem_req, mem_addr, ib_valid, dbg_state} !== {1'b1, 16'h1234, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL drop_target_req: got req=%b addr=%h v=%b st=%0d want req=1 addr=1234 v=0 st=1",
                     mem_req, mem_addr, ib_valid, dbg_state);
        end
        step();
        ib_ready  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = byte_at(16'h1234);
        settle();
        step();
        mem_ack = 1'b0;
        settle();
        n_checks++;
        if ({ib_valid, ib_pc, ib_data, mem_addr} !== {1'b1, 16'h1234, byte_at(16'h1234), 16'h1235}) begin
            n_fail++;
            $display("FAIL drop_first_byte: got v=%b pc=%h d=%h addr=%h want v=1 pc=1234 d=%h addr=1235",
                     ib_valid, ib_pc, ib_data, mem_addr, byte_at(16'h1234));
        end
    endtask

    task automatic test_retarget();
        apply_reset();
        step();
        jmp_valid  = 1'b1;
        jmp_target = 16'h1111;
        step();
        jmp_target = 16'h2222;
        settle();
        n_checks++;
        if (dbg_state !== 2'd2) begin
            n_fail++;
            $display("FAIL retarget_drop: got st=%0d want st=2", dbg_state);
        end
        step();
        jmp_valid = 1'b0;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        settle();
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h2222}) begin
            n_fail++;
            $display("FAIL retarget_latest: got req=%b addr=%h want req=1 addr=2222", mem_req, mem_addr);
        end
    endtask

    task automatic test_redirect_with_ack();
        apply_reset();
        ib_ready = 1'b0;
        step();
        mem_ack   = 1'b1;
        mem_rdata = byte_at(16'hFFFC);
        step();
        ib_ready   = 1'b1;
        mem_rdata  = 8'h99;
        jmp_valid  = 1'b1;
        jmp_target = 16'h4000;
        settle();
        n_checks++;
        if ({ib_valid, ib_pc, mem_addr} !== {1'b1, 16'hFFFC, 16'hFFFD}) begin
            n_fail++;
            $display("FAIL jmpack_before: got v=%b pc=%h addr=%h want v=1 pc=fffc addr=fffd", ib_valid, ib_pc, mem_addr);
        end
        step();
        mem_ack   = 1'b0;
        jmp_valid = 1'b0;
        ib_ready  = 1'b0;
        settle();
        n_checks++;
        if ({ib_valid, mem_req, mem_addr, dbg_state} !== {1'b0, 1'b1, 16'h4000, 2'd1}) begin
            n_fail++;
            $display("FAIL jmpack_flush: got v=%b req=%b addr=%h st=%0d want v=0 req=1 addr=4000 st=1",
                     ib_valid, mem_req, mem_addr, dbg_state);
        end
        step();
        mem_ack   = 1'b1;
        mem_rdata = byte_at(16'h4000);
        step();
        mem_ack = 1'b0;
        settle();
        n_checks++;
        if ({ib_valid, ib_pc, ib_data} !== {1'b1, 16'h4000, byte_at(16'h4000)}) begin
            n_fail++;
            $display("FAIL jmpack_target_byte: got v=%b pc=%h d=%h want v=1 pc=4000 d=%h", ib_valid, ib_pc, ib_data, byte_at(16'h4000));
        end
    endtask

    task automatic test_redirect_idle();
        apply_reset();
        jmp_valid  = 1'b1;
        jmp_target = 16'h0800;
        step();
        jmp_valid = 1'b0;
        settle();
        n_checks++;
        if ({mem_req, dbg_state} !== {1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL idle_jmp_hold: got req=%b st=%0d want req=0 st=0", mem_req, dbg_state);
        end
        step();
        settle();
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0800}) begin
            n_fail++;
            $display("FAIL idle_jmp_req: got req=%b addr=%h want req=1 addr=0800", mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ib_ready = 1'b0;
        step();
        mem_ack   = 1'b1;
        mem_rdata = byte_at(16'hFFFC);
        step();
        mem_rdata = byte_at(16'hFFFD);
        step();
        mem_ack = 1'b0;
        settle();
        n_checks++;
        if ({mem_req, mem_addr, ib_valid, ib_pc} !== {1'b1, 16'hFFFE, 1'b1, 16'hFFFC}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got req=%b addr=%h v=%b pc=%h want req=1 addr=fffe v=1 pc=fffc", mem_req, mem_addr, ib_valid, ib_pc);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_addr, ib_valid, ib_data, ib_pc, dbg_state} !== {1'b0, 16'hFFFC, 1'b0, 8'h00, 16'h0000, 2'd0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got req=%b addr=%h v=%b d=%h pc=%h st=%0d want reset values",
                     mem_req, mem_addr, ib_valid, ib_data, ib_pc, dbg_state);
        end
        mem_ack   = 1'b1;
        mem_rdata = 8'h77;
        step();
        rst = 1'b1;
        step();
        settle();
        n_checks++;
        if ({mem_req, mem_addr, ib_valid} !== {1'b1, 16'hFFFC, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_late_ack: got req=%b addr=%h v=%b want req=1 addr=fffc v=0", mem_req, mem_addr, ib_valid);
        end
        mem_ack = 1'b0;
        step();
        settle();
        n_checks++;
        if ({ib_valid, mem_addr} !== {1'b0, 16'hFFFC}) begin
            n_fail++;
            $display("FAIL rstmid_no_byte: got v=%b addr=%h want v=0 addr=fffc", ib_valid, mem_addr);
        end
    endtask

    task automatic test_bypass_latency();
        apply_reset();
        ib_ready = 1'b1;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 8'hA7;
        settle();
        n_checks++;
`ifdef FETCH_BYPASS_EN
        if ({ib_valid, ib_data, ib_pc} !== {1'b1, 8'hA7, 16'hFFFC}) begin
`else
        if (ib_valid !== 1'b0) begin
`endif
            n_fail++;
            $display("FAIL latency_ack_cycle: got v=%b d=%h pc=%h", ib_valid, ib_data, ib_pc);
        end
        step();
        mem_ack = 1'b0;
        settle();
        n_checks++;
`ifdef FETCH_BYPASS_EN
        if (ib_valid !== 1'b0) begin
`else
        if ({ib_valid, ib_data, ib_pc} !== {1'b1, 8'hA7, 16'hFFFC}) begin
`endif
            n_fail++;
            $display("FAIL latency_next_cycle: got v=%b d=%h pc=%h", ib_valid, ib_data, ib_pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        apply_reset();
        ib_ready = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            exp       = 16'hFFFC + 16'(i);
            mem_ack   = 1'b1;
            mem_rdata = byte_at(exp);
            settle();
            n_checks++;
            if ({mem_req, mem_addr} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL b2b_req[%0d]: got req=%b addr=%h want req=1 addr=%h", i, mem_req, mem_addr, exp);
            end
`ifdef FETCH_BYPASS_EN
            n_checks++;
            if ({ib_valid, ib_pc, ib_data} !== {1'b1, exp, byte_at(exp)}) begin
                n_fail++;
                $display("FAIL b2b_byte[%0d]: got v=%b pc=%h d=%h want pc=%h", i, ib_valid, ib_pc, ib_data, exp);
            end
`else
            if (i == 0) begin
                n_checks++;
                if (ib_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_first: got v=%b want v=0", ib_valid);
                end
            end else begin
                n_checks++;
                if ({ib_valid, ib_pc, ib_data} !== {1'b1, exp - 16'd1, byte_at(exp - 16'd1)}) begin
                    n_fail++;
                    $display("FAIL b2b_byte[%0d]: got v=%b pc=%h d=%h want pc=%h", i, ib_valid, ib_pc, ib_data, exp - 16'd1);
                end
            end
`endif
            step();
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_fill();
        test_redirect_drop();
        test_retarget();
        test_redirect_with_ack();
        test_redirect_idle();
        test_reset_mid();
        test_bypass_latency();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
